// File: rtl/vector_mem_sequencer_pkg.sv
// vector_mem_pkg: FSM encoding and beat-geometry helpers shared by vector_mem_sequencer
package vector_mem_pkg;
  typedef logic [2:0] state_t;
  localparam state_t IDLE = 3'd0;
  localparam state_t SLD  = 3'd1;
  localparam state_t VST  = 3'd2;
  localparam state_t VLD  = 3'd3;
  localparam state_t DONE = 3'd4;
  function automatic int beats_f(input int v, input int n);
    return v / n;
  endfunction
  function automatic int word_bytes_f(input int n);
    return n / 8;
  endfunction
  function automatic int cnt_w_f(input int v, input int n);
    return $clog2(v / n + 1);
  endfunction
endpackage

// File: rtl/vector_mem_sequencer_if.sv
// vector_mem_sequencer_if: MEM-stage request, writeback response and memory port bundle (VMEM_STRIDE_EN adds req_stride)
interface vector_mem_sequencer_if #(
  parameter int V = 128,
  parameter int N = 32
);
  logic         req_valid;
  logic         req_vec;
  logic         req_we;
  logic [N-1:0] req_addr;
  logic [N-1:0] req_wdata;
  logic [V-1:0] req_wvector;
`ifdef VMEM_STRIDE_EN
  logic [N-1:0] req_stride;
`endif
  logic         stall_cpu;
  logic         resp_valid;
  logic [N-1:0] resp_data;
  logic [V-1:0] resp_vector;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         mem_we;
  logic [N-1:0] mem_rdata;
  modport master (
`ifdef VMEM_STRIDE_EN
    output req_stride,
`endif
    output req_valid, req_vec, req_we, req_addr, req_wdata, req_wvector, mem_rdata,
    input  stall_cpu, resp_valid, resp_data, resp_vector, mem_addr, mem_wdata, mem_we
  );
  modport slave (
`ifdef VMEM_STRIDE_EN
    input  req_stride,
`endif
    input  req_valid, req_vec, req_we, req_addr, req_wdata, req_wvector, mem_rdata,
    output stall_cpu, resp_valid, resp_data, resp_vector, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/vector_mem_sequencer.sv
// vector_mem_sequencer: shares one N-bit memory port between scalar and V-bit vector accesses (VMEM_STRIDE_EN: per-request beat stride)
module vector_mem_sequencer
  import vector_mem_pkg::*;
#(
  parameter int V = 128,
  parameter int N = 32
) (
  input logic clk,
  input logic rst,
  vector_mem_sequencer_if.slave bus
);
  localparam int BEATS = beats_f(V, N);
  localparam int WORD_BYTES = word_bytes_f(N);
  localparam int CW = cnt_w_f(V, N);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, beat;
  logic [N-1:0] base_q, base_d, stride_q, stride_d, stride_in;
  logic [N-1:0] resp_data_q, resp_data_d, addr, wdata;
  logic [V-1:0] vec_q, vec_d, resp_vector_q, resp_vector_d;
  logic resp_valid_q, resp_valid_d, stall, we, last_vld;
`ifdef VMEM_STRIDE_EN
  assign stride_in = bus.req_stride;
`else
  assign stride_in = N'(WORD_BYTES);
`endif
  assign last_vld = (state_q == VLD) && (cnt_q == CW'(BEATS));
  assign beat = last_vld ? cnt_q - 1'b1 : cnt_q;
  // beat sequencing: issue beat 0 from the live request, later beats from latched copies
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    base_d = base_q;
    stride_d = stride_q;
    vec_d = vec_q;
    resp_data_d = resp_data_q;
    resp_vector_d = resp_vector_q;
    resp_valid_d = 1'b0;
    stall = 1'b0;
    we = 1'b0;
    addr = base_q + N'(beat) * stride_q;
    wdata = '0;
    case (state_q)
      IDLE: begin
        addr = bus.req_addr;
        we = bus.req_valid & bus.req_we;
        wdata = bus.req_vec ? bus.req_wvector[N-1:0] : bus.req_wdata;
        if (bus.req_valid) begin
          base_d = bus.req_addr;
          stride_d = stride_in;
          vec_d = bus.req_wvector;
          stall = bus.req_vec | ~bus.req_we;
          cnt_d = bus.req_vec ? CW'(1) : cnt_q;
          state_d = !bus.req_vec ? (bus.req_we ? IDLE : SLD) : (!bus.req_we ? VLD : (BEATS == 1 ? DONE : VST));
        end
      end
      SLD: begin
        stall = 1'b1;
        resp_data_d = bus.mem_rdata;
        resp_valid_d = 1'b1;
        state_d = DONE;
      end
      VST: begin
        stall = 1'b1;
        we = 1'b1;
        wdata = vec_q[int'(cnt_q) * N +: N];
        state_d = (cnt_q == CW'(BEATS - 1)) ? DONE : VST;
        cnt_d = (cnt_q == CW'(BEATS - 1)) ? cnt_q : cnt_q + 1'b1;
      end
      VLD: begin
        stall = 1'b1;
        resp_vector_d[(int'(cnt_q) - 1) * N +: N] = bus.mem_rdata;
        state_d = last_vld ? DONE : VLD;
        cnt_d = last_vld ? cnt_q : cnt_q + 1'b1;
        resp_valid_d = last_vld;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state, latched request and result registers; reset aborts and clears results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      stride_q <= '0;
      vec_q <= '0;
      resp_data_q <= '0;
      resp_vector_q <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      base_q <= base_d;
      stride_q <= stride_d;
      vec_q <= vec_d;
      resp_data_q <= resp_data_d;
      resp_vector_q <= resp_vector_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign bus.stall_cpu = stall & ~rst;
  assign bus.mem_we = we & ~rst;
  assign bus.mem_addr = rst ? '0 : addr;
  assign bus.mem_wdata = rst ? '0 : wdata;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data = resp_data_q;
  assign bus.resp_vector = resp_vector_q;
endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb_vector_mem_sequencer: table-driven and randomized checks of vector_mem_sequencer against a memory-level model
module tb_vector_mem_sequencer;
  localparam int V = 128;
  localparam int N = 32;
  localparam int BEATS = V / N;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  vector_mem_sequencer_if #(.V(V), .N(N)) bus ();
  vector_mem_sequencer #(.V(V), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction
  // synchronous memory seen by the DUT: read data one cycle after the address
  always @(posedge clk) begin
    if (rst) bus.mem_rdata <= '0;
    else begin
      bus.mem_rdata <= env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : dflt(bus.mem_addr);
      if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // reference model: what each op must do, stated at the memory-transaction level
  int m_stall;
  logic m_rv;
  logic [3:0][31:0] m_addr, m_data;
  logic [31:0] m_rdata = '0;
  logic [127:0] m_rvec = '0;
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  task automatic model_apply(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [127:0] vw);
    int n = v ? BEATS : 1;
    m_stall = v ? (w ? BEATS : BEATS + 1) : (w ? 0 : 2);
    m_rv = !w;
    for (int k = 0; k < 4; k++) begin
      m_addr[k] = a + 32'(k * 4);
      m_data[k] = v ? vw[k*32 +: 32] : d;
    end
    for (int k = 0; k < n; k++) begin
      if (w) ref_mem[m_addr[k]] = m_data[k];
      else if (v) m_rvec[k*32 +: 32] = ref_rd(m_addr[k]);
      else m_rdata = ref_rd(a);
    end
  endtask
  // observation of one op: drive it, watch every cycle until the pipeline is released
  int obs_stall;
  bit obs_early_rv, obs_done;
  logic [31:0] w_addr[$], w_data[$], r_addr[$];
  logic obs_rv;
  logic [31:0] obs_rdata;
  logic [127:0] obs_rvec;
  task automatic run_op(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [127:0] vw);
    bus.req_valid = 1'b1;
    bus.req_vec = v;
    bus.req_we = w;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_wvector = vw;
    obs_stall = 0;
    obs_early_rv = 0;
    obs_done = 0;
    w_addr.delete();
    w_data.delete();
    r_addr.delete();
    for (int c = 0; c < 20 && !obs_done; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin
        w_addr.push_back(bus.mem_addr);
        w_data.push_back(bus.mem_wdata);
      end
      if (bus.stall_cpu) begin
        if (!bus.mem_we) r_addr.push_back(bus.mem_addr);
        if (bus.resp_valid) obs_early_rv = 1;
        obs_stall++;
      end else begin
        obs_rv = bus.resp_valid;
        obs_rdata = bus.resp_data;
        obs_rvec = bus.resp_vector;
        obs_done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!obs_done) obs_stall = -1;
    bus.req_valid = 1'b0;
  endtask
  task automatic verify(input string tag, input logic v, input logic w, input int exp_stall, input logic [3:0][31:0] ea,
                        input logic [3:0][31:0] ed, input logic exp_rv, input logic [31:0] exp_rdata, input logic [127:0] exp_rvec);
    int n = v ? BEATS : 1;
    chk({tag, " stall_cycles"}, 128'(obs_stall), 128'(exp_stall));
    chk({tag, " resp_valid_during_stall"}, 128'(obs_early_rv), 128'(0));
    chk({tag, " write_count"}, 128'(w_addr.size()), 128'(w ? n : 0));
    if (w) begin
      for (int k = 0; k < n && k < w_addr.size(); k++) begin
        chk($sformatf("%s wr_addr%0d", tag, k), 128'(w_addr[k]), 128'(ea[k]));
        chk($sformatf("%s wr_data%0d", tag, k), 128'(w_data[k]), 128'(ed[k]));
      end
    end else begin
      chk({tag, " read_count_ok"}, 128'(r_addr.size() >= n), 128'(1));
      for (int k = 0; k < n && k < r_addr.size(); k++)
        chk($sformatf("%s rd_addr%0d", tag, k), 128'(r_addr[k]), 128'(ea[k]));
    end
    chk({tag, " resp_valid"}, 128'(obs_rv), 128'(exp_rv));
    chk({tag, " resp_data"}, 128'(obs_rdata), 128'(exp_rdata));
    chk({tag, " resp_vector"}, obs_rvec, exp_rvec);
  endtask
  typedef struct {
    logic v;
    logic w;
    logic [31:0] a;
    logic [31:0] d;
    logic [127:0] vw;
    int stall;
    logic [3:0][31:0] ea;
    logic rv;
    logic [127:0] resp;
  } vec_t;
  vec_t tbl [12];
  initial begin
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 128'h0, 0, {96'h0, 32'h100}, 1'b0, 128'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'h200, 32'h12345678, 128'h0, 0, {96'h0, 32'h200}, 1'b0, 128'h0};
    tbl[2]  = '{1'b0, 1'b1, 32'h80, 32'hA0A0A0A0, 128'h0, 0, {96'h0, 32'h80}, 1'b0, 128'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h84, 32'hA1A1A1A1, 128'h0, 0, {96'h0, 32'h84}, 1'b0, 128'h0};
    tbl[4]  = '{1'b0, 1'b1, 32'h88, 32'hA2A2A2A2, 128'h0, 0, {96'h0, 32'h88}, 1'b0, 128'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'h8C, 32'hA3A3A3A3, 128'h0, 0, {96'h0, 32'h8C}, 1'b0, 128'h0};
    tbl[6]  = '{1'b0, 1'b0, 32'h200, 32'h0, 128'h0, 2, {96'h0, 32'h200}, 1'b1, {96'h0, 32'h12345678}};
    tbl[7]  = '{1'b1, 1'b1, 32'h40, 32'h0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4,
                {32'h4C, 32'h48, 32'h44, 32'h40}, 1'b0, 128'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h80, 32'h0, 128'h0, 5, {32'h8C, 32'h88, 32'h84, 32'h80}, 1'b1,
                {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}};
    tbl[9]  = '{1'b0, 1'b0, 32'h100, 32'h0, 128'h0, 2, {96'h0, 32'h100}, 1'b1, {96'h0, 32'hDEADBEEF}};
    tbl[10] = '{1'b1, 1'b1, 32'hFFFFFFF8, 32'h0, {32'hCAFE0003, 32'h0BADF00D, 32'hCAFE0001, 32'hCAFE0000}, 4,
                {32'h00000004, 32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFF8}, 1'b0, 128'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 32'h0, 128'h0, 2, {96'h0, 32'h0}, 1'b1, {96'h0, 32'h0BADF00D}};
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_vec = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wvector = '0;
`ifdef VMEM_STRIDE_EN
    bus.req_stride = 32'd4;
`endif
    @(negedge clk);
    chk("reset stall_cpu", 128'(bus.stall_cpu), 128'(0));
    chk("reset mem_we", 128'(bus.mem_we), 128'(0));
    chk("reset mem_addr", 128'(bus.mem_addr), 128'(0));
    chk("reset mem_wdata", 128'(bus.mem_wdata), 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset resp_valid", 128'(bus.resp_valid), 128'(0));
    chk("post-reset resp_data", 128'(bus.resp_data), 128'(0));
    chk("post-reset resp_vector", bus.resp_vector, 128'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      model_apply(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].vw);
      run_op(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].vw);
      verify($sformatf("row%0d", i), tbl[i].v, tbl[i].w, tbl[i].stall, tbl[i].ea, m_data, tbl[i].rv,
             (!tbl[i].v && !tbl[i].w) ? tbl[i].resp[31:0] : m_rdata,
             (tbl[i].v && !tbl[i].w) ? tbl[i].resp : m_rvec);
    end
    bus.req_valid = 1'b1;
    bus.req_vec = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = 32'h80;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort vld2 stall_cpu", 128'(bus.stall_cpu), 128'(1));
    chk("abort vld2 mem_addr", 128'(bus.mem_addr), 128'(32'h88));
    rst = 1'b1;
    @(negedge clk);
    chk("abort rst stall_cpu", 128'(bus.stall_cpu), 128'(0));
    chk("abort rst mem_we", 128'(bus.mem_we), 128'(0));
    chk("abort rst mem_addr", 128'(bus.mem_addr), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort idle%0d stall/we", c), {bus.stall_cpu, bus.mem_we}, 128'(0));
      chk($sformatf("abort idle%0d resp_valid", c), 128'(bus.resp_valid), 128'(0));
      @(posedge clk);
      #1;
    end
    chk("abort resp_vector", bus.resp_vector, 128'(0));
    chk("abort resp_data", 128'(bus.resp_data), 128'(0));
    m_rdata = '0;
    m_rvec = '0;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] t;
      logic [31:0] a, d;
      logic [127:0] vw;
      t = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : 32'h1000 + 32'($urandom_range(0, 15) * 4);
      d = $urandom;
      vw = {$urandom, $urandom, $urandom, $urandom};
      model_apply(t[1], t[0], a, d, vw);
      run_op(t[1], t[0], a, d, vw);
      verify($sformatf("rand%0d", i), t[1], t[0], m_stall, m_addr, m_data, m_rv, m_rdata, m_rvec);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        chk($sformatf("rand%0d idle stall/we", i), {bus.stall_cpu, bus.mem_we}, 128'(0));
        @(posedge clk);
        #1;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
